// File: rtl/mc_datapath_regs_pkg.sv
// rtl/mc_datapath_regs_pkg.sv - shared MIPS constants and instruction field layout
package mips_pkg;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type view; I-type immediate is {rd, shamt, funct}, J target is everything below op
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

endpackage

// File: rtl/mc_datapath_regs_if.sv
// rtl/mc_datapath_regs_if.sv - control strobes, ALU/memory/regfile buses of the datapath stage
interface mc_datapath_regs_if #(
    parameter int WIDTH = 32
);
    logic             IorD, ALUSrcA, IRWrite, PCWrite;
    logic             Branch, BranchNE, RegDst, MemtoReg;
    logic [1:0]       PCSrc, ALUSrcB;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] rf_rd1, rf_rd2;
    logic [WIDTH-1:0] mem_addr, mem_wdata;
    logic [WIDTH-1:0] src_a, src_b;
    logic [4:0]       rf_ra1, rf_ra2, rf_wa;
    logic [WIDTH-1:0] rf_wd;
    logic [5:0]       opcode, funct;
    logic [WIDTH-1:0] pc, instr;
    logic [31:0]      instr_count;

    modport master (
        output IorD, ALUSrcA, IRWrite, PCWrite, Branch, BranchNE, RegDst, MemtoReg,
        output PCSrc, ALUSrcB, alu_result, alu_zero, mem_rdata, rf_rd1, rf_rd2,
        input  mem_addr, mem_wdata, src_a, src_b, rf_ra1, rf_ra2, rf_wa, rf_wd,
        input  opcode, funct, pc, instr, instr_count
    );

    modport slave (
        input  IorD, ALUSrcA, IRWrite, PCWrite, Branch, BranchNE, RegDst, MemtoReg,
        input  PCSrc, ALUSrcB, alu_result, alu_zero, mem_rdata, rf_rd1, rf_rd2,
        output mem_addr, mem_wdata, src_a, src_b, rf_ra1, rf_ra2, rf_wa, rf_wd,
        output opcode, funct, pc, instr, instr_count
    );
endinterface

// File: rtl/mc_datapath_regs_flopenr.sv
// rtl/mc_datapath_regs_flopenr.sv - enable flop with async active-high reset to a parameter value
module flopenr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/mc_datapath_regs.sv
// rtl/mc_datapath_regs.sv - multicycle MIPS non-architectural registers and control-driven steering
module mc_datapath_regs
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              rst,
    mc_datapath_regs_if.slave bus
);
    logic [WIDTH-1:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [WIDTH-1:0] next_pc, signimm;
    logic [31:0]      count_q;
    logic [15:0]      imm16;
    logic             pc_en;
    instr_t           f;

    assign f       = ir_q[31:0];
    assign imm16   = {f.rd, f.shamt, f.funct};
    assign signimm = {{(WIDTH-16){imm16[15]}}, imm16};

    // One next_pc serves both unconditional writes and taken branches
    assign pc_en = bus.PCWrite | (bus.Branch & (bus.BranchNE ? ~bus.alu_zero : bus.alu_zero));

    always_comb begin
        next_pc = pc_q;
        unique case (bus.PCSrc)
            PCSRC_ALU:    next_pc = bus.alu_result;
            PCSRC_ALUOUT: next_pc = aluout_q;
            PCSRC_JUMP:   next_pc = {pc_q[WIDTH-1:28], f.rs, f.rt, imm16, 2'b00};
            default:      next_pc = pc_q;
        endcase
    end

    flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .d(next_pc), .q(pc_q)
    );

    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
        .clk(clk), .rst(rst), .en(bus.IRWrite), .d(bus.mem_rdata), .q(ir_q)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(32'd0)) u_count (
        .clk(clk), .rst(rst), .en(bus.IRWrite), .d(count_q + 32'd1), .q(count_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            mdr_q    <= bus.mem_rdata;
            a_q      <= bus.rf_rd1;
            b_q      <= bus.rf_rd2;
            aluout_q <= bus.alu_result;
        end
    end

    always_comb begin
        bus.src_b = b_q;
        unique case (bus.ALUSrcB)
            SRCB_REG:    bus.src_b = b_q;
            SRCB_FOUR:   bus.src_b = WIDTH'(32'd4);
            SRCB_IMM:    bus.src_b = signimm;
            SRCB_IMM_SH: bus.src_b = {signimm[WIDTH-3:0], 2'b00};
            default:     bus.src_b = b_q;
        endcase
    end

    assign bus.mem_addr    = bus.IorD ? aluout_q : pc_q;
    assign bus.mem_wdata   = b_q;
    assign bus.src_a       = bus.ALUSrcA ? a_q : pc_q;
    assign bus.rf_ra1      = f.rs;
    assign bus.rf_ra2      = f.rt;
    assign bus.rf_wa       = bus.RegDst ? f.rd : f.rt;
    assign bus.rf_wd       = bus.MemtoReg ? mdr_q : aluout_q;
    assign bus.opcode      = f.op;
    assign bus.funct       = f.funct;
    assign bus.pc          = pc_q;
    assign bus.instr       = ir_q;
    assign bus.instr_count = count_q;

endmodule
